sub_cells_serial: RTL and testbench

- Area-reduced, serialized SubCells layer for the QARMA round datapath.
- Accepts a full N-bit cipher state through a valid/ready handshake and substitutes CELLS_PER_CYCLE cells per clock, using the team's general S-box (4-bit cells for N=64, 8-bit cells for N=128).
- Returns the substituted state downstream through a second valid/ready handshake.
- Sits between the round-key/tweak addition stage (upstream) and the ShuffleCells/MixColumns stage (downstream).

---
 rtl/sub_cells_serial.sv | 124 ++++++++++++
 tb/tb_sub_cells_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_cells_serial.sv
// Serialized QARMA SubCells: substitutes CELLS_PER_CYCLE cells per clock; 16/CPC cycles in RUN, result held in DONE until out_ready.
// Optional macro SUB_CELLS_BACK2BACK_EN lets a new state enter on the same edge the previous result leaves.
// Backpressure: out_ready low in DONE holds out_data stable indefinitely; in_ready is low while busy.
module sub_cells_serial #(
    parameter int          N               = 128,
    parameter logic [63:0] SIGMA           = 64'h0,
    parameter bit          INV             = 1'b0,
    parameter int          CELLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);
    localparam int M   = N / 16;
    localparam int CPC = CELLS_PER_CYCLE;

    if (!(N == 64 || N == 128)) begin : g_bad_n
        $error("sub_cells_serial: N must be 64 or 128");
    end
    if (!(CPC == 1 || CPC == 2 || CPC == 4 || CPC == 8 || CPC == 16)) begin : g_bad_cpc
        $error("sub_cells_serial: CELLS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [N-1:0] sreg;
    logic [M-1:0] sub [CPC];
    logic         last_grp;
    logic         accept;

    function automatic logic [3:0] tab(input logic [3:0] k);
        return SIGMA[63 - 4*k -: 4];
    endfunction

    // 8-bit cells split into even/odd bit planes, each pushed through the 4-bit table.
    function automatic logic [M-1:0] sbox(input logic [M-1:0] v);
        logic [7:0] x;
        logic [7:0] r;
        logic [3:0] lo;
        logic [3:0] hi;
        x = 8'(v);
        r = '0;
        if (M == 4) begin
            r = {4'h0, tab(x[3:0])};
        end else if (!INV) begin
            lo = tab(x[3:0]);
            hi = tab(x[7:4]);
            for (int b = 0; b < 4; b++) begin
                r[2*b]     = lo[b];
                r[2*b + 1] = hi[b];
            end
        end else begin
            lo = tab({x[6], x[4], x[2], x[0]});
            hi = tab({x[7], x[5], x[3], x[1]});
            r  = {hi, lo};
        end
        return r[M-1:0];
    endfunction

    assign last_grp = (cnt == 4'(16 - CPC));
    assign accept   = in_valid && in_ready;
    assign out_data = sreg;

    always_comb begin
        for (int j = 0; j < CPC; j++) begin
            sub[j] = sbox(sreg[(int'(cnt) + j)*M +: M]);
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_grp) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef SUB_CELLS_BACK2BACK_EN
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? RUN : IDLE;
`else
                if (out_ready) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sreg <= in_data;
                cnt  <= '0;
            end else if (state == RUN) begin
                for (int j = 0; j < CPC; j++) begin
                    sreg[(int'(cnt) + j)*M +: M] <= sub[j];
                end
                cnt <= last_grp ? 4'd0 : cnt + 4'(CPC);
            end
        end
    end
endmodule

// File: tb/tb_sub_cells_serial.sv
// Bench for sub_cells_serial: three configurations (N=128 forward, N=128 inverse, N=64) checked against a cell-level model.
module tb_sub_cells_serial;
    localparam logic [63:0] S1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] S2 = 64'h0E2A9F8B6437DC15;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   iv = '0;
    logic [2:0]   ordy = '1;
    logic [2:0]   ir, ov, bsy;
    logic [127:0] din [3];
    logic [127:0] dout0, dout1;
    logic [63:0]  dout2;
    logic [127:0] dout [3];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        dout[0] = dout0;
        dout[1] = dout1;
        dout[2] = {64'h0, dout2};
    end

    sub_cells_serial #(.N(128), .SIGMA(S1), .INV(1'b0), .CELLS_PER_CYCLE(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout0), .busy(bsy[0]));
    sub_cells_serial #(.N(128), .SIGMA(S1), .INV(1'b1), .CELLS_PER_CYCLE(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout1), .busy(bsy[1]));
    sub_cells_serial #(.N(64), .SIGMA(S2), .INV(1'b0), .CELLS_PER_CYCLE(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2][63:0]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout2), .busy(bsy[2]));

    typedef struct {
        int           id;
        logic [127:0] d;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    function automatic int tab(logic [63:0] sg, int k);
        return int'((sg >> (4*(15 - k))) & 64'hF);
    endfunction

    // Reference: per-cell arithmetic straight from the substitution rules.
    function automatic logic [127:0] model(int id, logic [127:0] x);
        logic [127:0] y;
        int           m;
        logic [63:0]  sg;
        y  = '0;
        m  = (id == 2) ? 4 : 8;
        sg = (id == 2) ? S2 : S1;
        for (int c = 0; c < 16; c++) begin
            int v, r, lo, hi;
            v = int'((x >> (m*c)) & ((128'd1 << m) - 128'd1));
            r = 0;
            if (m == 4) begin
                r = tab(sg, v);
            end else if (id == 0) begin
                lo = tab(sg, v % 16);
                hi = tab(sg, v / 16);
                for (int b = 0; b < 4; b++)
                    r += (((lo >> b) & 1) << (2*b)) + (((hi >> b) & 1) << (2*b + 1));
            end else begin
                lo = 0;
                hi = 0;
                for (int b = 0; b < 4; b++) begin
                    lo += ((v >> (2*b)) & 1) << b;
                    hi += ((v >> (2*b + 1)) & 1) << b;
                end
                r = tab(sg, hi) * 16 + tab(sg, lo);
            end
            y |= 128'(r) << (m*c);
        end
        return y;
    endfunction

    function automatic int lat_of(int id);
        return (id == 0) ? 17 : (id == 1) ? 5 : 9;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transfer; latency counts edges from the accept edge (inclusive) to the edge raising out_valid.
    task automatic xfer(int id, logic [127:0] d, logic [127:0] exp, int lat, string nm);
        int n;
        @(negedge clk);
        chk({nm, " in_ready idle"}, 128'(ir[id]), 128'd1);
        din[id]  = d;
        iv[id]   = 1'b1;
        ordy[id] = 1'b1;
        @(posedge clk);
        #1;
        iv[id]  = 1'b0;
        din[id] = ~d;
        n = 1;
        while (!ov[id] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 128'(n), 128'(lat));
        chk({nm, " data"}, dout[id], exp);
        @(posedge clk);
        #1;
        chk({nm, " back to idle"}, 128'({ov[id], bsy[id]}), 128'd0);
    endtask

    initial begin
        vec_t         tbl [5];
        logic [127:0] d, exp, held;
        int           nx, nt, n;
        int           t [3];

        tbl[0] = '{0, {16{8'hF0}}, {16{8'hAA}}, 17};
        tbl[1] = '{1, {16{8'hAA}}, {16{8'hF0}}, 5};
        tbl[2] = '{2, {64'h0, 64'h0123456789ABCDEF}, {64'h0, 64'h0E2A9F8B6437DC15}, 9};
        tbl[3] = '{2, {64'h0, 64'hFFFFFFFFFFFFFFFF}, {64'h0, 64'h5555555555555555}, 9};
        tbl[4] = '{0, 128'h0, 128'h0, 17};
        for (int i = 0; i < 3; i++) din[i] = '0;

        #12;
        chk("reset in_ready", 128'(ir), 128'h7);
        chk("reset out_valid", 128'(ov), 128'h0);
        chk("reset busy", 128'(bsy), 128'h0);
        chk("reset out_data", dout0, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            xfer(tbl[i].id, tbl[i].d, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));

        for (int r = 0; r < 30; r++) begin
            int id;
            id = r % 3;
            d  = {$urandom, $urandom, $urandom, $urandom};
            if (id == 2) d[127:64] = '0;
            xfer(id, d, model(id, d), lat_of(id), $sformatf("rand%0d", r));
        end

        // Backpressure in DONE with in_data/in_valid toggling.
        d = {$urandom, $urandom, $urandom, $urandom};
        exp = model(0, d);
        @(negedge clk);
        din[0] = d; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp data", dout0, exp);
        held = dout0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            din[0] = {$urandom, $urandom, $urandom, $urandom};
            iv[0]  = k[0];
            @(posedge clk);
            #1;
            chk("bp stable", dout0, held);
            chk("bp in_ready", 128'(ir[0]), 128'd0);
            chk("bp out_valid", 128'(ov[0]), 128'd1);
        end
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        nx = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (ov[0] && ordy[0]) nx++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp transfers", 128'(nx), 128'd1);

        // Asynchronous reset in RUN cycle 7.
        @(negedge clk);
        din[0] = {$urandom, $urandom, $urandom, $urandom}; iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre-reset busy", 128'(bsy[0]), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst out_valid", 128'(ov[0]), 128'd0);
        chk("rst busy", 128'(bsy[0]), 128'd0);
        chk("rst in_ready", 128'(ir[0]), 128'd1);
        chk("rst out_data", dout0, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        xfer(0, d, model(0, d), 17, "post-reset");

        // Continuous in_valid with out_ready held high.
        d = {$urandom, $urandom, $urandom, $urandom};
        exp = model(0, d);
        @(negedge clk);
        din[0] = d; iv[0] = 1'b1; ordy[0] = 1'b1;
        nt = 0; n = 0;
        while (nt < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ov[0]) begin
                t[nt] = cyc;
                nt++;
                chk("b2b data", dout0, exp);
`ifdef SUB_CELLS_BACK2BACK_EN
                chk("b2b in_ready done", 128'(ir[0]), 128'd1);
`else
                chk("b2b in_ready done", 128'(ir[0]), 128'd0);
`endif
            end
        end
        chk("b2b outputs seen", 128'(nt), 128'd3);
        if (nt == 3) begin
`ifdef SUB_CELLS_BACK2BACK_EN
            chk("b2b spacing 1", 128'(t[1] - t[0]), 128'd17);
            chk("b2b spacing 2", 128'(t[2] - t[1]), 128'd17);
`else
            chk("b2b spacing 1", 128'(t[1] - t[0]), 128'd18);
            chk("b2b spacing 2", 128'(t[2] - t[1]), 128'd18);
`endif
        end
        @(negedge clk);
        iv[0] = 1'b0;
        n = 0;
        while (bsy[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain idle", 128'(bsy[0]), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
